psr_stack_register: RTL

//  Parametrised program-status register: NZCV-style flags plus IRQ-mask bit and processor mode.
//  Per-bit masked flag updates from the ALU. MSR-style writes from the control unit.

---
 rtl/psr_pkg.sv | 27 ++
 rtl/psr_lifo.sv | 57 +++++
 rtl/psr_stack_register.sv | 114 +++++++++++
 3 files changed

// File: rtl/psr_pkg.sv
// Shared PSR layout constants: default field widths, bit offsets, mode encodings and flag indices.
package psr_pkg;

  localparam int PSR_FLAG_W = 4;
  localparam int PSR_MODE_W = 5;
  localparam int PSR_W_DEF  = PSR_FLAG_W + 1 + PSR_MODE_W;

  // Bit offsets inside the packed {flags, I, mode} word for the default widths
  localparam int MODE_LSB = 0;
  localparam int IRQ_BIT  = PSR_MODE_W;
  localparam int FLAG_LSB = PSR_MODE_W + 1;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [PSR_MODE_W-1:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011
  } psr_mode_e;

endpackage

// File: rtl/psr_lifo.sv
// DEPTH-entry register stack holding saved PSR words; full pushes and empty pops are dropped.
module psr_lifo #(
  parameter  int W     = 10,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !do_push;
  assign count   = count_reg;

  // One register per slot, written only when it is the next free position
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[gi] <= '0;
      end else if (do_push && (count_reg == CW'(gi))) begin
        mem[gi] <= din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (do_push) begin
      count_reg <= count_reg + 1'b1;
    end else if (do_pop) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_reg == CW'(i + 1)) top = mem[i];
    end
  end

endmodule

// File: rtl/psr_stack_register.sv
// Program status register {flags, I, mode} with masked ALU flag updates, MSR writes
// and an exception save stack.
module psr_stack_register
  import psr_pkg::*;
#(
  parameter  int               FLAG_W     = PSR_FLAG_W,
  parameter  int               MODE_W     = PSR_MODE_W,
  parameter  int               DEPTH      = 4,
  parameter  logic [MODE_W-1:0] RESET_MODE = MODE_W'(MODE_SVC),
  parameter  logic [MODE_W-1:0] USER_MODE  = MODE_W'(MODE_USR),
  localparam int               PSR_W      = FLAG_W + 1 + MODE_W,
  localparam int               CW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_en,
  input  logic [FLAG_W-1:0] flag_d,
  input  logic [FLAG_W-1:0] flag_mask,
  input  logic              msr_en,
  input  logic [PSR_W-1:0]  msr_d,
  input  logic              exc_en,
  input  logic [MODE_W-1:0] exc_mode,
  input  logic              ret_en,
  input  logic              clr_err,
  output logic [PSR_W-1:0]  q,
  output logic [FLAG_W-1:0] flags,
  output logic [MODE_W-1:0] mode,
  output logic [PSR_W-1:0]  spsr_q,
  output logic [CW-1:0]     count,
  output logic              ovf,
  output logic              unf
);

  logic [FLAG_W-1:0] flags_reg, flags_next, fl_merged;
  logic              irq_reg, irq_next;
  logic [MODE_W-1:0] mode_reg, mode_next;
  logic              ovf_reg, unf_reg, ovf_set, unf_set;
  logic              push, pop, full, empty;
  logic [PSR_W-1:0]  top;

  assign fl_merged = flag_en ? ((flags_reg & ~flag_mask) | (flag_d & flag_mask)) : flags_reg;

  always_comb begin
    flags_next = flags_reg;
    irq_next   = irq_reg;
    mode_next  = mode_reg;
    push       = 1'b0;
    pop        = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (exc_en) begin
      // Flag merge still applies so the saved word carries this cycle's ALU result
      push       = !full;
      ovf_set    = full;
      flags_next = fl_merged;
      irq_next   = 1'b1;
      mode_next  = exc_mode;
    end else if (ret_en) begin
      if (!empty) begin
        pop = 1'b1;
        {flags_next, irq_next, mode_next} = top;
      end else begin
        unf_set = 1'b1;
      end
    end else if (msr_en) begin
      flags_next = msr_d[PSR_W-1 -: FLAG_W];
      if (mode_reg != USER_MODE) begin
        irq_next  = msr_d[MODE_W];
        mode_next = msr_d[MODE_W-1:0];
      end
    end else if (flag_en) begin
      flags_next = fl_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= '0;
      irq_reg   <= 1'b1;
      mode_reg  <= RESET_MODE;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      irq_reg   <= irq_next;
      mode_reg  <= mode_next;
      ovf_reg   <= ovf_set | (ovf_reg & ~clr_err);
      unf_reg   <= unf_set | (unf_reg & ~clr_err);
    end
  end

  psr_lifo #(
    .W     (PSR_W),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({fl_merged, irq_reg, mode_reg}),
    .top   (top),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign q      = {flags_reg, irq_reg, mode_reg};
  assign flags  = flags_reg;
  assign mode   = mode_reg;
  assign spsr_q = top;
  assign ovf    = ovf_reg;
  assign unf    = unf_reg;

endmodule
